// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the SAP-style controller/sequencer: opcodes, control-word
// layout, inactive word and one-hot ring states.
package controller_sequencer_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned RING_W   = 6;
   localparam int unsigned CW_W     = 12;

   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   // Control word ordering: {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
   localparam int unsigned CW_CP   = 11;
   localparam int unsigned CW_EP   = 10;
   localparam int unsigned CW_LM_N = 9;
   localparam int unsigned CW_CE_N = 8;
   localparam int unsigned CW_LI_N = 7;
   localparam int unsigned CW_EI_N = 6;
   localparam int unsigned CW_LA_N = 5;
   localparam int unsigned CW_EA   = 4;
   localparam int unsigned CW_SU   = 3;
   localparam int unsigned CW_EU   = 2;
   localparam int unsigned CW_LB_N = 1;
   localparam int unsigned CW_LO_N = 0;

   localparam logic [CW_W-1:0] CW_INACTIVE = 12'h3E3;

   localparam logic [RING_W-1:0] T1 = 6'b000001;
   localparam logic [RING_W-1:0] T2 = 6'b000010;
   localparam logic [RING_W-1:0] T3 = 6'b000100;
   localparam logic [RING_W-1:0] T4 = 6'b001000;
   localparam logic [RING_W-1:0] T5 = 6'b010000;
   localparam logic [RING_W-1:0] T6 = 6'b100000;

   function automatic logic is_one_hot(input logic [RING_W-1:0] x);
      return (x != '0) && ((x & (x - RING_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// Opcode input and decoded control/status outputs of the controller/sequencer.
interface controller_sequencer_if;
   import controller_sequencer_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic                Cp;
   logic                Ep;
   logic                Lm_n;
   logic                CE_n;
   logic                Li_n;
   logic                Ei_n;
   logic                La_n;
   logic                Ea;
   logic                Su;
   logic                Eu;
   logic                Lb_n;
   logic                Lo_n;
   logic [RING_W-1:0]   t_state;
   logic                halted;

   modport master (
      input  opcode,
      output Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n,
      output t_state, halted
   );

   modport slave (
      output opcode,
      input  Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n,
      input  t_state, halted
   );

endinterface

// File: rtl/controller_sequencer_ring.sv
// Six-state one-hot timing ring; freezes on hold, self-recovers to T1 from any
// corrupted (non-one-hot) value.
module ring_counter
   import controller_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              clr_n,
   input  logic              hold,
   output logic [RING_W-1:0] t_state
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         t_state <= T1;
      end else if (!is_one_hot(t_state)) begin
         t_state <= T1;
      end else if (!hold) begin
         t_state <= {t_state[RING_W-2:0], t_state[RING_W-1]};
      end
   end

endmodule

// File: rtl/controller_sequencer.sv
// Controller/sequencer: ring timing, halt flag and combinational control-word
// decode from the current T-state and instruction opcode.
module controller_sequencer
   import controller_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  clr_n,
   controller_sequencer_if.master bus
);

   logic [RING_W-1:0] t_state;
   logic              halted;
   logic              hlt_at_t4_c;
   logic              hold_c;
   logic [CW_W-1:0]   cw_c;

   assign hlt_at_t4_c = (t_state == T4) && (bus.opcode == OP_HLT);
   assign hold_c      = halted || hlt_at_t4_c;

   ring_counter u_ring (
      .clk     (clk),
      .clr_n   (clr_n),
      .hold    (hold_c),
      .t_state (t_state)
   );

   // Halt is sticky until reset
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         halted <= 1'b0;
      end else if (hlt_at_t4_c) begin
         halted <= 1'b1;
      end
   end

   always_comb begin
      cw_c = CW_INACTIVE;
      if (!halted) begin
         case (t_state)
            T1: begin
               cw_c[CW_EP]   = 1'b1;
               cw_c[CW_LM_N] = 1'b0;
            end
            T2: cw_c[CW_CP] = 1'b1;
            T3: begin
               cw_c[CW_CE_N] = 1'b0;
               cw_c[CW_LI_N] = 1'b0;
            end
            T4: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     cw_c[CW_LM_N] = 1'b0;
                     cw_c[CW_EI_N] = 1'b0;
                  end
                  OP_OUT: begin
                     cw_c[CW_EA]   = 1'b1;
                     cw_c[CW_LO_N] = 1'b0;
                  end
                  default: cw_c = CW_INACTIVE;
               endcase
            end
            T5: begin
               case (bus.opcode)
                  OP_LDA: begin
                     cw_c[CW_CE_N] = 1'b0;
                     cw_c[CW_LA_N] = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     cw_c[CW_CE_N] = 1'b0;
                     cw_c[CW_LB_N] = 1'b0;
                  end
                  default: cw_c = CW_INACTIVE;
               endcase
            end
            T6: begin
               if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
                  cw_c[CW_LA_N] = 1'b0;
                  cw_c[CW_EU]   = 1'b1;
                  cw_c[CW_SU]   = (bus.opcode == OP_SUB);
               end
            end
            default: cw_c = CW_INACTIVE;
         endcase
      end
   end

   assign bus.Cp      = cw_c[CW_CP];
   assign bus.Ep      = cw_c[CW_EP];
   assign bus.Lm_n    = cw_c[CW_LM_N];
   assign bus.CE_n    = cw_c[CW_CE_N];
   assign bus.Li_n    = cw_c[CW_LI_N];
   assign bus.Ei_n    = cw_c[CW_EI_N];
   assign bus.La_n    = cw_c[CW_LA_N];
   assign bus.Ea      = cw_c[CW_EA];
   assign bus.Su      = cw_c[CW_SU];
   assign bus.Eu      = cw_c[CW_EU];
   assign bus.Lb_n    = cw_c[CW_LB_N];
   assign bus.Lo_n    = cw_c[CW_LO_N];
   assign bus.t_state = t_state;
   assign bus.halted  = halted;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: fetch, per-opcode execute words,
// halt, asynchronous reset and bus-driver exclusivity under random opcodes.
module tb_controller_sequencer;

   logic clk;
   logic clr_n;
   int   checks;
   int   errors;

   controller_sequencer_if bus ();

   controller_sequencer dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   logic [11:0] cw_obs;
   assign cw_obs = {bus.Cp, bus.Ep, bus.Lm_n, bus.CE_n, bus.Li_n, bus.Ei_n,
                    bus.La_n, bus.Ea, bus.Su, bus.Eu, bus.Lb_n, bus.Lo_n};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed control words
   localparam logic [11:0] W_IDLE  = 12'h3E3;
   localparam logic [11:0] W_T1    = 12'h5E3;
   localparam logic [11:0] W_T2    = 12'hBE3;
   localparam logic [11:0] W_T3    = 12'h263;
   localparam logic [11:0] W_MEM4  = 12'h1A3;
   localparam logic [11:0] W_LDA5  = 12'h2C3;
   localparam logic [11:0] W_ALU5  = 12'h2E1;
   localparam logic [11:0] W_ADD6  = 12'h3C7;
   localparam logic [11:0] W_SUB6  = 12'h3CF;
   localparam logic [11:0] W_OUT4  = 12'h3F2;

   // Short reset pulse between edges; leaves the DUT in T1 mid-cycle
   task automatic pulse_reset();
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      clr_n = 1'b1;
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [11:0] w4,
                            input logic [11:0] w5, input logic [11:0] w6,
                            input string name);
      logic [11:0] exp_w [6];
      logic [5:0]  exp_t;
      exp_w[0] = W_T1; exp_w[1] = W_T2; exp_w[2] = W_T3;
      exp_w[3] = w4;   exp_w[4] = w5;   exp_w[5] = w6;
      bus.opcode = op;
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         exp_t = 6'b000001 << (i % 6);
         checks++;
         if (bus.t_state !== exp_t || cw_obs !== exp_w[i % 6]) begin
            errors++;
            $display("FAIL %s T%0d: t_state=%b cw=%h, expected t_state=%b cw=%h",
                     name, (i % 6) + 1, bus.t_state, cw_obs, exp_t, exp_w[i % 6]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.opcode = 4'h0;
      clr_n = 1'b0;
      #12;
      checks++;
      if (bus.t_state !== 6'b000001 || bus.halted !== 1'b0 || cw_obs !== W_T1) begin
         errors++;
         $display("FAIL reset: t_state=%b halted=%b cw=%h, expected 000001 0 %h",
                  bus.t_state, bus.halted, cw_obs, W_T1);
      end
      @(negedge clk);
      checks++;
      if (bus.t_state !== 6'b000001 || cw_obs !== W_T1) begin
         errors++;
         $display("FAIL reset_held: t_state=%b cw=%h, expected 000001 %h",
                  bus.t_state, cw_obs, W_T1);
      end
      clr_n = 1'b1;
   endtask

   task automatic test_opcodes();
      run_instr(4'h0, W_MEM4, W_LDA5, W_IDLE, "lda");
      run_instr(4'h1, W_MEM4, W_ALU5, W_ADD6, "add");
      run_instr(4'h2, W_MEM4, W_ALU5, W_SUB6, "sub");
      run_instr(4'hE, W_OUT4, W_IDLE, W_IDLE, "out");
      run_instr(4'h7, W_IDLE, W_IDLE, W_IDLE, "undef7");
      run_instr(4'hA, W_IDLE, W_IDLE, W_IDLE, "undefA");
   endtask

   task automatic test_halt();
      bus.opcode = 4'hF;
      pulse_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.t_state !== 6'b001000 || bus.halted !== 1'b0 || cw_obs !== W_IDLE) begin
         errors++;
         $display("FAIL hlt_t4: t_state=%b halted=%b cw=%h, expected 001000 0 %h",
                  bus.t_state, bus.halted, cw_obs, W_IDLE);
      end
      // Opcode changes after halt must not wake the decode
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.opcode = 4'(i % 3);
         #1;
         checks++;
         if (bus.t_state !== 6'b001000 || bus.halted !== 1'b1 || cw_obs !== W_IDLE) begin
            errors++;
            $display("FAIL halted_%0d: t_state=%b halted=%b cw=%h, expected 001000 1 %h",
                     i, bus.t_state, bus.halted, cw_obs, W_IDLE);
         end
      end
   endtask

   task automatic test_reset_mid();
      // Reset while halted clears the flag immediately
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      checks++;
      if (bus.halted !== 1'b0 || bus.t_state !== 6'b000001 || cw_obs !== W_T1) begin
         errors++;
         $display("FAIL reset_in_halt: halted=%b t_state=%b cw=%h, expected 0 000001 %h",
                  bus.halted, bus.t_state, cw_obs, W_T1);
      end
      clr_n = 1'b1;
      // Reset in the middle of T5 of an ADD
      bus.opcode = 4'h1;
      pulse_reset();
      repeat (4) @(negedge clk);
      checks++;
      if (bus.t_state !== 6'b010000) begin
         errors++;
         $display("FAIL pre_abort: t_state=%b, expected 010000", bus.t_state);
      end
      #2;
      clr_n = 1'b0;
      #1;
      checks++;
      if (bus.t_state !== 6'b000001 || bus.halted !== 1'b0 || cw_obs !== W_T1) begin
         errors++;
         $display("FAIL abort_t5: t_state=%b halted=%b cw=%h, expected 000001 0 %h",
                  bus.t_state, bus.halted, cw_obs, W_T1);
      end
      #1;
      clr_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.t_state !== 6'b000010 || cw_obs !== W_T2) begin
         errors++;
         $display("FAIL resume_t2: t_state=%b cw=%h, expected 000010 %h",
                  bus.t_state, cw_obs, W_T2);
      end
   endtask

   task automatic test_random_exclusive();
      int drivers;
      bus.opcode = 4'h0;
      pulse_reset();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         bus.opcode = 4'($urandom_range(0, 15));
         if (bus.halted === 1'b1 && (i % 40) == 0) begin
            clr_n = 1'b0;
            #1;
            clr_n = 1'b1;
         end
         #1;
         drivers = int'(bus.Ep) + int'(!bus.CE_n) + int'(!bus.Ei_n) +
                   int'(bus.Ea) + int'(bus.Eu);
         checks++;
         if (drivers > 1 || (bus.halted === 1'b1 && cw_obs !== W_IDLE)) begin
            errors++;
            $display("FAIL exclusive_%0d: drivers=%0d halted=%b cw=%h t_state=%b op=%h, expected drivers<=1",
                     i, drivers, bus.halted, cw_obs, bus.t_state, bus.opcode);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr_n  = 1'b1;
      bus.opcode = 4'h0;
      test_reset();
      test_opcodes();
      test_halt();
      test_reset_mid();
      test_random_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: clr_n  input  1  asynchronous active-low reset.
REQ-004 Port: opcode  input  4  instruction-register upper nibble; valid during T4-T6.
REQ-005 Port: Cp  output  1  program-counter increment, active high.
REQ-006 Port: Ep  output  1  program-counter bus enable, active high.
REQ-007 Port: Lm_n  output  1  memory-address-register load, active low.
REQ-008 Port: CE_n  output  1  RAM bus enable, active low.
REQ-009 Port: Li_n / Ei_n  output  1 each  instruction-register load / operand-field bus enable, active low.
REQ-010 Port: La_n / Ea  output  1 each  accumulator load (active low) / accumulator bus enable (active high).
REQ-011 Port: Su / Eu  output  1 each  ALU subtract select / ALU bus enable, active high.
REQ-012 Port: Lb_n / Lo_n  output  1 each  B-register load / output-register load, active low.
REQ-013 Port: t_state  output  6  one-hot ring state, bit0=T1 ... bit5=T6.
REQ-014 Port: halted  output  1  high once HLT has executed.

Function
REQ-015 The ring counter SHALL advance T1->T2->...->T6->T1 on each rising clk edge while halted=0.
REQ-016 The control outputs SHALL be decoded combinationally from t_state and opcode. Control changes within the same cycle as the state, with no extra latency.
REQ-017 Inactive control word (Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n) SHALL be 12'h3E3. Every signal not listed for a state SHALL hold its inactive value.
REQ-018 Fetch, opcode ignored: T1 Ep=1,Lm_n=0; T2 Cp=1; T3 CE_n=0,Li_n=0.
REQ-019 LDA (4'h0): T4 Lm_n=0,Ei_n=0; T5 CE_n=0,La_n=0; T6 inactive.
REQ-020 ADD (4'h1): T4 Lm_n=0,Ei_n=0; T5 CE_n=0,Lb_n=0; T6 La_n=0,Eu=1,Su=0.
REQ-021 SUB (4'h2): same as ADD except T6 Su=1.
REQ-022 OUT (4'hE): T4 Ea=1,Lo_n=0; T5, T6 inactive.
REQ-023 HLT (4'hF): T4 inactive.
REQ-024 On the rising edge ending T4 with opcode=4'hF, halted SHALL set and the ring SHALL freeze at T4.
REQ-025 While halted=1, all controls SHALL be inactive (12'h3E3) regardless of opcode.
REQ-026 Only reset SHALL clear halted.
REQ-027 Undefined opcodes SHALL give inactive controls in T4-T6, and the ring SHALL continue.
REQ-028 At most one bus driver (Ep, CE_n low, Ei_n low, Ea, Eu) SHALL be active in any state, for any opcode.
REQ-029 A non-one-hot t_state SHALL load T1 on the next edge.

Reset
REQ-030 clr_n=0 SHALL immediately force t_state=6'b000001 and halted=0, independent of clk.
REQ-031 While clr_n=0, outputs SHALL equal the T1 decode.
REQ-032 Assertion of clr_n mid-instruction, including during halt, SHALL abort the instruction. Fetch restarts at T1 on the first rising edge after release, with T1 held for that edge.

Structure
REQ-033 A shared package SHALL hold: opcode constants (LDA, ADD, SUB, OUT, HLT), control-word bit indices, the 12'h3E3 inactive word, and the T1-T6 one-hot constants.
REQ-034 The 6-bit one-hot ring SHALL be a sub-module ring_counter (clk, clr_n, hold, t_state). The decode and halt flag stay in controller_sequencer.

Verification
REQ-035 Reset then 3 clocks, opcode=4'h0 -> T1 word Ep=1,Lm_n=0; T2 Cp=1; T3 CE_n=0,Li_n=0.
REQ-036 opcode=4'h2 through a full 6-cycle instruction -> T6 La_n=0,Eu=1,Su=1; opcode=4'h1 gives the same with Su=0.
REQ-037 opcode=4'hF reaches T4 -> halted=1 after that edge; t_state stays 6'b001000 for 10 cycles; controls stay 12'h3E3.
REQ-038 clr_n pulsed low mid-T5 between clock edges -> t_state=6'b000001 immediately; halted=0; resumes T2 one edge after release.
REQ-039 opcode=4'h7 -> T4-T6 controls 12'h3E3; t_state returns to T1 after T6.
REQ-040 Random opcodes over 1000 cycles -> bus-driver exclusivity (REQ-028) never violated.
